alu_nibble_sequencer: RTL and testbench
=======================================

Name: alu_nibble_sequencer

Overview:
- Initiator side of the 4-bit ALU slice interface: A_/B_/S/M/Cn driven out, F/Cn4 consumed back.
- Accepts one wide operation (WIDTH = 4*NIBBLES bits) through a valid/ready request.
- Issues it to one external combinational 4-bit ALU slice, one nibble per cycle, LSB nibble first, chaining carry.
- Assembles the wide result, carry-out and A=B flag, and returns them through a valid/ready response. Sits between a datapath controller and a single shared ALU slice.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; must be >= 1; WIDTH = 4*NIBBLES (16 at default).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_s  in  4  ALU function select
- req_m  in  1  mode (1 = logic, 0 = arithmetic)
- req_cn  in  1  carry-in to the least-significant nibble, slice polarity
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_f  out  WIDTH  assembled result
- resp_cn4  out  1  carry-out of the most-significant nibble, slice polarity
- resp_aeqb  out  1  1 when every nibble of F equals 4'hF
- alu_a  out  4  slice operand A nibble
- alu_b  out  4  slice operand B nibble
- alu_s  out  4  slice select
- alu_m  out  1  slice mode
- alu_cn  out  1  slice carry-in
- alu_f  in  4  slice result, combinational from the alu_* outputs
- alu_cn4  in  1  slice carry-out, combinational

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-low on rst_n. All state is in flops on clk rising edge.
- Reset values:
  - state = IDLE, nibble index = 0
  - resp_valid = 0, resp_f = 0, resp_cn4 = 0, resp_aeqb = 0
  - captured operands = 0, alu_a = alu_b = alu_s = 0, alu_m = 1, alu_cn = 1
  - req_ready = 1 (IDLE)
- FSM states:
  - IDLE:
    - req_ready = 1.
    - On a clock edge with req_valid & req_ready: capture req_a, req_b, req_s, req_m; set carry register = req_cn; idx = 0; aeqb accumulator = 1; go to RUN.
  - RUN:
    - req_ready = 0.
    - Slice outputs are driven from registers only (no combinational path from req_* to alu_*):
      - alu_a = A[4*idx +: 4], alu_b = B[4*idx +: 4]
      - alu_s and alu_m = captured values
      - alu_cn = carry register
    - Each edge:
      - result[4*idx +: 4] <= alu_f
      - carry register <= alu_cn4
      - aeqb accumulator <= accumulator & (alu_f == 4'hF)
      - idx <= idx + 1
    - On the edge where idx == NIBBLES-1, go to DONE instead of incrementing.
  - DONE:
    - resp_valid = 1.
    - resp_f = result register, resp_cn4 = carry register, resp_aeqb = accumulator.
    - All three are stable while resp_valid is high and resp_ready is low.
    - On an edge with resp_ready = 1, go to IDLE.
- Outside RUN, slice outputs return to their reset values.
- Carry polarity: the sequencer never inverts carry. alu_cn4 of nibble k feeds alu_cn of nibble k+1 unchanged. Polarity is whatever the slice uses.
- Logic mode: M = 1 still chains carry. The slice ignores it; resp_cn4 is then the slice's don't-care output, passed through.
- Latency:
  - Request accepted at edge E.
  - RUN occupies cycles E+1 .. E+NIBBLES.
  - resp_valid is high from the cycle after edge E+NIBBLES.
  - Minimum request-to-request spacing is NIBBLES+2 cycles, given resp_ready is held at 1.
- No pipelining: req_ready = 0 in RUN and DONE. A req_valid asserted then is held off, not dropped (standard valid/ready).
- NIBBLES = 1: RUN lasts exactly one cycle.
- idx width is clog2(NIBBLES), minimum 1 bit; it never wraps past NIBBLES-1.
- rst_n low in any state, including mid-RUN or in DONE with resp_valid high:
  - The operation is aborted immediately (asynchronous).
  - Outputs go to reset values; no response is ever produced for the aborted request.
- resp_valid and resp_* are registered outputs, with no combinational dependence on resp_ready.

Test Plan:
- The bench connects a behavioural 74181-compatible slice model: active-high data, active-low Cn/Cn4.
- ADD (S=1001, M=0, cn=1 meaning no carry), A=0x1234, B=0x0FFF -> resp_f=0x2233, resp_cn4=1; resp_valid exactly 5 cycles after the accepting edge.
- ADD overflow (S=1001, M=0, cn=1), A=0xFFFF, B=0x0001 -> resp_f=0x0000, resp_cn4=0 (carry out); alu_cn observed 1,0,0,0 across the four RUN cycles.
- SUB with compare (S=0110, M=0, cn=1 meaning A-B-1), A=B=0x5555 -> resp_f=0xFFFF, resp_aeqb=1; repeat with B=0x5554 -> resp_f=0x0000, resp_aeqb=0.
- Logic XOR (S=0110, M=1), A=0xF0F0, B=0xFF00 -> resp_f=0x0FF0; alu_m=1 held for all RUN cycles.
- Backpressure:
  - Hold resp_ready=0 for 6 cycles after resp_valid.
  - Required: resp_f/resp_cn4/resp_aeqb stable, req_ready=0, and a second req_valid is not accepted.
  - Then resp_ready=1 for one cycle -> IDLE, second request accepted the next edge.
- Reset mid-operation: assert rst_n=0 during the 2nd RUN cycle of an ADD. Required: req_ready=1, resp_valid=0, alu_m=1, alu_cn=1 immediately, with no response after release. A following ADD 0x0001+0x0001 -> resp_f=0x0002.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// Drives one external 4-bit ALU slice nibble-by-nibble (LSB first) to execute a
// WIDTH-bit operation, chaining the slice carry and assembling F, Cn4 and A=B.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic [3:0]           req_s,
  input  logic                 req_m,
  input  logic                 req_cn,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [4*NIBBLES-1:0] resp_f,
  output logic                 resp_cn4,
  output logic                 resp_aeqb,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_cn,
  input  logic [3:0]           alu_f,
  input  logic                 alu_cn4
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             aeqb_q, aeqb_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      aeqb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      aeqb_q   <= aeqb_d;
    end
  end

  // The carry register holds the slice-polarity carry; it is never inverted.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    carry_d  = carry_q;
    result_d = result_q;
    aeqb_d   = aeqb_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          s_d     = req_s;
          m_d     = req_m;
          carry_d = req_cn;
          idx_d   = '0;
          aeqb_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[{idx_q, 2'b00} +: 4] = alu_f;
        carry_d = alu_cn4;
        aeqb_d  = aeqb_q & (alu_f == 4'hF);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slice and response outputs come from registers only, idle values otherwise.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);
    resp_f     = (state_q == DONE) ? result_q : '0;
    resp_cn4   = (state_q == DONE) ? carry_q : 1'b0;
    resp_aeqb  = (state_q == DONE) ? aeqb_q : 1'b0;
    alu_a      = 4'h0;
    alu_b      = 4'h0;
    alu_s      = 4'h0;
    alu_m      = 1'b1;
    alu_cn     = 1'b1;
    if (state_q == RUN) begin
      alu_a  = a_q[{idx_q, 2'b00} +: 4];
      alu_b  = b_q[{idx_q, 2'b00} +: 4];
      alu_s  = s_q;
      alu_m  = m_q;
      alu_cn = carry_q;
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer with a behavioural 74181-style slice attached:
// directed vector table, hand-written corner sequences and random operations.
module tb_alu_nibble_sequencer;

  localparam int NIBBLES = 4;
  localparam int WIDTH   = 4 * NIBBLES;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cn;
    logic [15:0] expF;
    logic        expCn4;
    logic        expAeqb;
  } vec_t;

  typedef struct {
    logic [15:0] f;
    logic        cn4;
    logic        aeqb;
    int          lat;
    logic [3:0]  cnSeq;
    logic        ctlOk;
    logic        abOk;
  } resp_t;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       req_s;
  logic             req_m;
  logic             req_cn;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_f;
  logic             resp_cn4;
  logic             resp_aeqb;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_s;
  logic             alu_m;
  logic             alu_cn;
  logic [3:0]       alu_f;
  logic             alu_cn4;
  logic [4:0]       sliceOut;

  int vectors;
  int miscompares;

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_s     (req_s),
    .req_m     (req_m),
    .req_cn    (req_cn),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_f    (resp_f),
    .resp_cn4  (resp_cn4),
    .resp_aeqb (resp_aeqb),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_m     (alu_m),
    .alu_cn    (alu_cn),
    .alu_f     (alu_f),
    .alu_cn4   (alu_cn4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic-mode operand pair: the slice computes X + Y + carry, bitwise X/Y.
  function automatic void pickXY(input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] s,
                                 output logic [15:0] x, output logic [15:0] y);
    case (s)
      4'h0: begin x = a;       y = 16'h0;   end
      4'h1: begin x = a | b;   y = 16'h0;   end
      4'h2: begin x = a | ~b;  y = 16'h0;   end
      4'h3: begin x = 16'h0;   y = 16'hFFFF; end
      4'h4: begin x = a;       y = a & ~b;  end
      4'h5: begin x = a | b;   y = a & ~b;  end
      4'h6: begin x = a;       y = ~b;      end
      4'h7: begin x = a & ~b;  y = 16'hFFFF; end
      4'h8: begin x = a;       y = a & b;   end
      4'h9: begin x = a;       y = b;       end
      4'hA: begin x = a | ~b;  y = a & b;   end
      4'hB: begin x = a & b;   y = 16'hFFFF; end
      4'hC: begin x = a;       y = a;       end
      4'hD: begin x = a | b;   y = a;       end
      4'hE: begin x = a | ~b;  y = a;       end
      default: begin x = a;    y = 16'hFFFF; end
    endcase
  endfunction

  function automatic logic [15:0] logicFn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s);
    case (s)
      4'h0: return ~a;
      4'h1: return ~(a | b);
      4'h2: return ~a & b;
      4'h3: return 16'h0;
      4'h4: return ~(a & b);
      4'h5: return ~b;
      4'h6: return a ^ b;
      4'h7: return a & ~b;
      4'h8: return ~a | b;
      4'h9: return ~(a ^ b);
      4'hA: return b;
      4'hB: return a & b;
      4'hC: return 16'hFFFF;
      4'hD: return a | ~b;
      4'hE: return a | b;
      default: return a;
    endcase
  endfunction

  // One 4-bit slice: active-high data, active-low carry in and out.
  function automatic logic [4:0] sliceNibble(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] s, input logic m,
                                             input logic cn);
    logic [15:0] x, y, lf;
    logic [4:0]  sum;
    pickXY({12'h0, a}, {12'h0, b}, s, x, y);
    sum = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0, ~cn};
    lf  = logicFn({12'h0, a}, {12'h0, b}, s);
    return {~sum[4], m ? lf[3:0] : sum[3:0]};
  endfunction

  // Whole-word reference for a full operation.
  function automatic vec_t wideModel(input logic [15:0] a, input logic [15:0] b,
                                     input logic [3:0] s, input logic m, input logic cn);
    vec_t v;
    logic [15:0] x, y;
    logic [16:0] sum;
    pickXY(a, b, s, x, y);
    sum = {1'b0, x} + {1'b0, y} + {16'h0, ~cn};
    v.a = a; v.b = b; v.s = s; v.m = m; v.cn = cn;
    v.expF    = m ? logicFn(a, b, s) : sum[15:0];
    v.expCn4  = ~sum[16];
    v.expAeqb = (v.expF == 16'hFFFF);
    return v;
  endfunction

  assign sliceOut = sliceNibble(alu_a, alu_b, alu_s, alu_m, alu_cn);
  assign alu_cn4  = sliceOut[4];
  assign alu_f    = sliceOut[3:0];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Starts after the accepting edge; watches RUN cycles until resp_valid.
  task automatic collectResponse(input vec_t v, output resp_t r);
    r.lat   = 0;
    r.cnSeq = 4'h0;
    r.ctlOk = 1'b1;
    r.abOk  = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) begin
        r.lat = cyc;
        break;
      end
      if (cyc <= NIBBLES) begin
        r.cnSeq[cyc-1] = alu_cn;
        if (alu_a !== v.a[4*(cyc-1) +: 4] || alu_b !== v.b[4*(cyc-1) +: 4]) r.abOk = 1'b0;
        if (alu_m !== v.m || alu_s !== v.s) r.ctlOk = 1'b0;
      end
    end
    r.f    = resp_f;
    r.cn4  = resp_cn4;
    r.aeqb = resp_aeqb;
  endtask

  // Entered on a negedge; presents the request and returns after the accepting edge.
  task automatic issueRequest(input vec_t v);
    int waitCnt;
    waitCnt = 0;
    while (!req_ready && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready) checkOutput("req_ready_timeout", 32'(req_ready), 32'd1);
    req_a     = v.a;
    req_b     = v.b;
    req_s     = v.s;
    req_m     = v.m;
    req_cn    = v.cn;
    req_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic ackResponse();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, output resp_t r);
    issueRequest(v);
    collectResponse(v, r);
  endtask

  task automatic checkResult(input string tag, input vec_t v, input resp_t r);
    checkOutput({tag, "_f"}, 32'(r.f), 32'(v.expF));
    checkOutput({tag, "_cn4"}, 32'(r.cn4), 32'(v.expCn4));
    checkOutput({tag, "_aeqb"}, 32'(r.aeqb), 32'(v.expAeqb));
    checkOutput({tag, "_latency"}, 32'(r.lat), 32'(NIBBLES + 1));
    checkOutput({tag, "_first_cn"}, 32'(r.cnSeq[0]), 32'(v.cn));
    checkOutput({tag, "_ctl_held"}, 32'(r.ctlOk), 32'd1);
    checkOutput({tag, "_ab_nibbles"}, 32'(r.abOk), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t  vecs[7];
    vec_t  v, v2;
    resp_t r;
    logic  stableOk, sawValid;
    logic [15:0] heldF;
    logic heldCn4, heldAeqb;

    vecs[0] = '{a: 16'h1234, b: 16'h0FFF, s: 4'h9, m: 1'b0, cn: 1'b1, expF: 16'h2233, expCn4: 1'b1, expAeqb: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, s: 4'h9, m: 1'b0, cn: 1'b1, expF: 16'h0000, expCn4: 1'b0, expAeqb: 1'b0};
    vecs[2] = '{a: 16'h5555, b: 16'h5555, s: 4'h6, m: 1'b0, cn: 1'b1, expF: 16'hFFFF, expCn4: 1'b1, expAeqb: 1'b1};
    vecs[3] = '{a: 16'h5555, b: 16'h5554, s: 4'h6, m: 1'b0, cn: 1'b1, expF: 16'h0000, expCn4: 1'b0, expAeqb: 1'b0};
    vecs[4] = '{a: 16'hF0F0, b: 16'hFF00, s: 4'h6, m: 1'b1, cn: 1'b1, expF: 16'h0FF0, expCn4: 1'b1, expAeqb: 1'b0};
    vecs[5] = '{a: 16'h1234, b: 16'h1234, s: 4'h9, m: 1'b1, cn: 1'b1, expF: 16'hFFFF, expCn4: 1'b1, expAeqb: 1'b1};
    vecs[6] = '{a: 16'h0001, b: 16'h0001, s: 4'h9, m: 1'b0, cn: 1'b1, expF: 16'h0002, expCn4: 1'b1, expAeqb: 1'b0};

    vectors     = 0;
    miscompares = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_s      = '0;
    req_m      = 1'b0;
    req_cn     = 1'b1;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_resp_f", 32'(resp_f), 32'd0);
    checkOutput("reset_alu_m_cn", {30'd0, alu_m, alu_cn}, 32'd3);
    checkOutput("reset_alu_abs", {20'd0, alu_a, alu_b, alu_s}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], r);
      checkResult($sformatf("vec%0d", i), vecs[i], r);
      if (i == 1) checkOutput("vec1_cn_chain", 32'(r.cnSeq), 32'h1);
      ackResponse();
      checkOutput($sformatf("vec%0d_back_idle", i), {30'd0, req_ready, resp_valid}, 32'd2);
    end

    // Backpressure: response must hold while a second request waits.
    applyStimulus(vecs[0], r);
    checkResult("bp_first", vecs[0], r);
    heldF = resp_f; heldCn4 = resp_cn4; heldAeqb = resp_aeqb;
    v2 = wideModel(16'h0001, 16'h0002, 4'h9, 1'b0, 1'b1);
    req_a = v2.a; req_b = v2.b; req_s = v2.s; req_m = v2.m; req_cn = v2.cn;
    req_valid = 1'b1;
    stableOk = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (resp_f !== heldF || resp_cn4 !== heldCn4 || resp_aeqb !== heldAeqb ||
          resp_valid !== 1'b1 || req_ready !== 1'b0) stableOk = 1'b0;
    end
    checkOutput("bp_hold_stable", 32'(stableOk), 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("bp_release_idle", {30'd0, req_ready, resp_valid}, 32'd2);
    @(posedge clk);
    collectResponse(v2, r);
    checkResult("bp_second", v2, r);
    ackResponse();

    // Reset during the second RUN cycle of an ADD aborts it without a response.
    v = vecs[0];
    issueRequest(v);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_ready_valid", {30'd0, req_ready, resp_valid}, 32'd2);
    checkOutput("abort_alu_m_cn", {30'd0, alu_m, alu_cn}, 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid) sawValid = 1'b1;
    end
    checkOutput("abort_no_response", 32'(sawValid), 32'd0);
    applyStimulus(vecs[6], r);
    checkResult("post_abort", vecs[6], r);
    ackResponse();

    // Random operations against the whole-word model.
    for (int i = 0; i < 40; i++) begin
      v = wideModel(16'($urandom), 16'($urandom), 4'($urandom_range(15, 0)),
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      applyStimulus(v, r);
      checkOutput($sformatf("rand%0d_f", i), 32'(r.f), 32'(v.expF));
      checkOutput($sformatf("rand%0d_cn4", i), 32'(r.cn4), 32'(v.expCn4));
      checkOutput($sformatf("rand%0d_aeqb", i), 32'(r.aeqb), 32'(v.expAeqb));
      checkOutput($sformatf("rand%0d_latency", i), 32'(r.lat), 32'(NIBBLES + 1));
      ackResponse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
